wb_ddr2_rr_arbiter: RTL and testbench
=====================================

# wb_ddr2_rr_arbiter

Round-robin Wishbone B3 arbiter that shares the single DDR2 controller slave port among up to 8 bus masters (CPU data, CPU instruction, DMA, video). Arbitrates fairly with a beat budget per grant. Hands the bus over only at transaction boundaries and breaks hung transfers with a watchdog. Sits between the master bus ports and the DDR2 interface's Wishbone slave.

## Interface
Parameters:
- NUM_MASTERS, 3: number of requesters, legal range 2..8.
- MAX_BEATS, 16: acks per grant after which the grant is surrendered at the next boundary if another master is waiting; legal range 1..255.
- TIMEOUT, 255: cycles with stb high and no ack before the watchdog fires; legal range 1..1023.

Ports (N = NUM_MASTERS):
- wb_clk  in  1  single clock for the whole block.
- wb_rst_n  in  1  asynchronous, active-low reset.
- wbm_cyc_i, wbm_stb_i, wbm_we_i  in  N each  per-master Wishbone controls; bit i belongs to master i.
- wbm_adr_i  in  32*N  per-master addresses; master i occupies bits [32i+31:32i].
- wbm_dat_i  in  32*N  per-master write data; same packing as wbm_adr_i.
- wbm_sel_i  in  4*N  per-master byte selects.
- wbm_cti_i  in  3*N  per-master cycle type identifiers.
- wbm_bte_i  in  2*N  per-master burst type extensions.
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  N each  per-master responses; wbm_rty_o is tied 0.
- wbm_dat_o  out  32  read data, shared by all masters.
- wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  controls to the DDR2 slave.
- wbs_adr_o  out  32  address to the DDR2 slave.
- wbs_dat_o  out  32  write data to the DDR2 slave.
- wbs_sel_o  out  4  byte selects to the DDR2 slave.
- wbs_cti_o  out  3  cycle type identifier to the DDR2 slave.
- wbs_bte_o  out  2  burst type extension to the DDR2 slave.
- wbs_ack_i  in  1  ack from the DDR2 slave.
- wbs_dat_i  in  32  read data from the DDR2 slave.
- grant_o  out  N  one-hot registered grant; 0 when no master holds the bus.
- wdt_event_o  out  1  one-cycle pulse each time the watchdog fires.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- IDLE
  - If any wbm_cyc_i is high, pick a winner by round-robin and go to GRANT.
  - The search starts at index last+1 and wraps modulo N.
  - After reset, last = N-1, so master 0 has top priority.
  - On the transition: grant_o and last are loaded with the winner, and the beat counter and watchdog are cleared.
- GRANT
  - All wbs_* outputs equal the granted master's inputs.
  - wbm_ack_o[g] = wbs_ack_i; all other wbm_ack_o bits are 0.
  - wbm_dat_o = wbs_dat_i at all times.
- Beat counter: increments on each wbs_ack_i and saturates at MAX_BEATS.
- Boundary: a cycle with wbs_ack_i high and granted cti equal to 3'b000 (classic) or 3'b111 (end of burst).
- Leave GRANT for RELEASE when any one of these holds:
  - (a) the granted master's wbm_cyc_i is low;
  - (b) the beat counter has reached MAX_BEATS, a boundary occurs, and some other wbm_cyc_i is high;
  - (c) the watchdog expires.
- Watchdog
  - Counts cycles in GRANT with stb high and wbs_ack_i low; clears on any ack.
  - On reaching TIMEOUT: wbm_err_o[g] and wdt_event_o pulse for that cycle, wbs_cyc_o/wbs_stb_o are forced to 0 in that same cycle, then the FSM goes to RELEASE.
- RELEASE
  - Exactly one cycle; grant_o = 0 and all wbs_* outputs are 0, then return to IDLE.
  - This guarantees the slave sees cyc low between owners.
- A preempted master under (b) keeps cyc high. It receives no ack while ungranted and is rearbitrated normally.
- Outside GRANT: wbs_* = 0, wbm_ack_o = 0, wbm_err_o = 0.

## Timing
- Reset values (async, on wb_rst_n low):
  - FSM = IDLE, grant_o = 0, last = N-1, counters = 0.
  - All wbs_*, wbm_ack_o, wbm_err_o, wdt_event_o = 0.
  - The effect is immediate, including mid-burst.
- Grant latency: master's cyc rises in cycle t in IDLE → grant_o and wbs_cyc_o high at t+1.
- Handover cost after a release decision in cycle t:
  - RELEASE in t+1, IDLE in t+2, next grant in t+3.
  - Minimum owner-to-owner gap is 2 dead cycles.
- The wbs_* mux, wbm_ack_o and wbm_dat_o are combinational from the registered grant; zero added latency for data or ack.
- Simultaneous events:
  - A master dropping cyc in the same cycle as an ack: the ack is still delivered and the FSM goes to RELEASE.
  - Watchdog expiry coinciding with an ack: the ack wins and the watchdog clears.

## Test plan
- Reset mid-burst: assert wb_rst_n=0 during master 1's 4-beat burst → all outputs 0 in that cycle; after release, master 0 requesting alone is granted 1 cycle later.
- Fairness, N=3: all three hold cyc with continuous classic single accesses → grants go 0,1,2,0,1,2; each owner gets exactly 16 acks; each handover has 2 dead cycles.
- Single master: master 2 does a 32-beat incrementing burst while the others are idle → no preemption; 32 acks delivered only on wbm_ack_o[2].
- Preemption boundary: master 0 in a 4-beat burst crosses MAX_BEATS=16 mid-burst while master 1 is waiting → handover only after the beat with cti=111; master 1 is granted 3 cycles later.
- Watchdog: TIMEOUT=8; the slave never acks master 1 → after 8 stalled cycles, wbm_err_o[1] and wdt_event_o each pulse once, wbs_cyc_o drops, and master 2 is granted next.
- Exit on cyc drop: master 0 drops cyc in the same cycle as its final ack → the ack is delivered, then RELEASE, then IDLE.

Source files
------------

// File: rtl/wb_ddr2_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one DDR2 controller slave port among
// several masters, with a per-grant beat budget and a stall watchdog.
module wb_ddr2_rr_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int MAX_BEATS   = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst_n,
  input  logic [NUM_MASTERS-1:0]     wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]     wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]     wbm_we_i,
  input  logic [32*NUM_MASTERS-1:0]  wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0]  wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]   wbm_sel_i,
  input  logic [3*NUM_MASTERS-1:0]   wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]   wbm_bte_i,
  output logic [NUM_MASTERS-1:0]     wbm_ack_o,
  output logic [NUM_MASTERS-1:0]     wbm_err_o,
  output logic [NUM_MASTERS-1:0]     wbm_rty_o,
  output logic [31:0]                wbm_dat_o,
  output logic                       wbs_cyc_o,
  output logic                       wbs_stb_o,
  output logic                       wbs_we_o,
  output logic [31:0]                wbs_adr_o,
  output logic [31:0]                wbs_dat_o,
  output logic [3:0]                 wbs_sel_o,
  output logic [2:0]                 wbs_cti_o,
  output logic [1:0]                 wbs_bte_o,
  input  logic                       wbs_ack_i,
  input  logic [31:0]                wbs_dat_i,
  output logic [NUM_MASTERS-1:0]     grant_o,
  output logic                       wdt_event_o,
  output logic [1:0]                 state_dbg
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0]   BEAT_MAX  = 8'(MAX_BEATS);
  localparam logic [7:0]   BEAT_LAST = 8'(MAX_BEATS - 1);
  localparam logic [9:0]   WDT_LAST  = 10'(TIMEOUT - 1);
  localparam logic [N-1:0] ONE_HOT0  = N'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;

  // Handshake: the owner's cyc/stb pass straight to the slave; a beat completes
  // in any cycle where the slave raises ack while the owner's stb is high.
  state_t         state;
  logic [N-1:0]   grant_q;
  logic [IW-1:0]  last;
  logic [7:0]     beat_cnt;
  logic [9:0]     wdt_cnt;

  logic           g_cyc, g_stb, g_we;
  logic [31:0]    g_adr, g_dat;
  logic [3:0]     g_sel;
  logic [2:0]     g_cti;
  logic [1:0]     g_bte;
  logic [IW-1:0]  winner;
  logic           found;
  int             cand;

  // last always holds the current owner while in GRANT
  always_comb begin
    g_cyc = 1'b0; g_stb = 1'b0; g_we = 1'b0;
    g_adr = '0; g_dat = '0; g_sel = '0; g_cti = '0; g_bte = '0;
    for (int i = 0; i < N; i++) begin
      if (last == IW'(i)) begin
        g_cyc = wbm_cyc_i[i];
        g_stb = wbm_stb_i[i];
        g_we  = wbm_we_i[i];
        g_adr = wbm_adr_i[32*i +: 32];
        g_dat = wbm_dat_i[32*i +: 32];
        g_sel = wbm_sel_i[4*i +: 4];
        g_cti = wbm_cti_i[3*i +: 3];
        g_bte = wbm_bte_i[2*i +: 2];
      end
    end
  end

  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last) + k;
      if (cand >= N) cand = cand - N;
      if (!found && wbm_cyc_i[cand]) begin
        winner = IW'(cand);
        found  = 1'b1;
      end
    end
  end

  logic wdt_fire, beat_hit, boundary, others_waiting, leave;

  assign wdt_fire       = (state == GRANT) && g_stb && !wbs_ack_i && (wdt_cnt == WDT_LAST);
  assign beat_hit       = (beat_cnt == BEAT_MAX) || (wbs_ack_i && beat_cnt == BEAT_LAST);
  assign boundary       = wbs_ack_i && (g_cti == 3'b000 || g_cti == 3'b111);
  assign others_waiting = |(wbm_cyc_i & ~grant_q);
  assign leave          = !g_cyc || (beat_hit && boundary && others_waiting) || wdt_fire;

  always_comb begin
    wbs_cyc_o = 1'b0; wbs_stb_o = 1'b0; wbs_we_o = 1'b0;
    wbs_adr_o = '0; wbs_dat_o = '0; wbs_sel_o = '0; wbs_cti_o = '0; wbs_bte_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    if (state == GRANT) begin
      wbs_cyc_o = g_cyc & ~wdt_fire;
      wbs_stb_o = g_stb & ~wdt_fire;
      wbs_we_o  = g_we;
      wbs_adr_o = g_adr;
      wbs_dat_o = g_dat;
      wbs_sel_o = g_sel;
      wbs_cti_o = g_cti;
      wbs_bte_o = g_bte;
      wbm_ack_o = grant_q & {N{wbs_ack_i}};
      wbm_err_o = grant_q & {N{wdt_fire}};
    end
  end

  assign wbm_rty_o   = '0;
  assign wbm_dat_o   = wbs_dat_i;
  assign grant_o     = grant_q;
  assign wdt_event_o = wdt_fire;
  assign state_dbg   = state;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      last     <= IW'(N - 1);
      beat_cnt <= '0;
      wdt_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|wbm_cyc_i) begin
            state    <= GRANT;
            grant_q  <= ONE_HOT0 << winner;
            last     <= winner;
            beat_cnt <= '0;
            wdt_cnt  <= '0;
          end
        end
        GRANT: begin
          if (wbs_ack_i && beat_cnt != BEAT_MAX) beat_cnt <= beat_cnt + 8'd1;
          if (wbs_ack_i)  wdt_cnt <= '0;
          else if (g_stb) wdt_cnt <= wdt_cnt + 10'd1;
          if (leave) begin
            state   <= RELEASE;
            grant_q <= '0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ddr2_rr_arbiter.sv
// Bench for wb_ddr2_rr_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level ownership model.
module tb_wb_ddr2_rr_arbiter;

  localparam int N    = 3;
  localparam int MAXB = 16;
  localparam int TMO  = 8;

  logic             wb_clk, wb_rst_n;
  logic [N-1:0]     wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [32*N-1:0]  wbm_adr_i, wbm_dat_i;
  logic [4*N-1:0]   wbm_sel_i;
  logic [3*N-1:0]   wbm_cti_i;
  logic [2*N-1:0]   wbm_bte_i;
  logic [N-1:0]     wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0]      wbm_dat_o;
  logic             wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [31:0]      wbs_adr_o, wbs_dat_o;
  logic [3:0]       wbs_sel_o;
  logic [2:0]       wbs_cti_o;
  logic [1:0]       wbs_bte_o;
  logic             wbs_ack_i;
  logic [31:0]      wbs_dat_i;
  logic [N-1:0]     grant_o;
  logic             wdt_event_o;
  logic [1:0]       state_dbg;

  wb_ddr2_rr_arbiter #(.NUM_MASTERS(N), .MAX_BEATS(MAXB), .TIMEOUT(TMO)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbm_dat_o(wbm_dat_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i),
    .grant_o(grant_o), .wdt_event_o(wdt_event_o), .state_dbg(state_dbg)
  );

  // clock / reset
  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // master programs
  bit          m_act[N], m_burst[N], m_auto[N];
  int          m_left[N], m_chain[N];
  logic        m_we[N];
  logic [31:0] m_adr[N], m_dat[N];
  logic [3:0]  m_sel[N];
  logic [1:0]  m_bte[N];

  // slave behaviour
  bit           gap_en, force_drop0, rnd_hang;
  int           ack_pct, hang_left;
  logic [N-1:0] hang_mask;

  // reference model: who owns the slave, and the rules that end ownership
  int md_owner, md_last, md_beats, md_stall;
  bit md_cool;

  // observation / scoreboard
  int            cyc_n;
  logic [N-1:0]  ob_grant, ob_ack, prev_grant;
  logic [1:0]    ob_state;
  int            ack_cnt[N], err_cnt[N], wdt_ev, wdt_cyc;
  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  ten_own_q[$];
  int            ten_ack_q[$], ten_dead_q[$], ten_start_q[$], ten_lack_q[$];
  logic [2:0]    ten_cti_q[$];
  int            cur_acks, cur_dead, cur_last_ack;
  logic [2:0]    cur_cti;

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    int best, bd, d;
    best = -1; bd = N + 1;
    for (int i = 0; i < N; i++) begin
      d = (i - last - 1 + N) % N;
      if (req[i] && d < bd) begin bd = d; best = i; end
    end
    return best;
  endfunction

  task automatic new_txn(input int i, input bit burst, input int len, input int chain);
    m_act[i] = 1; m_burst[i] = burst; m_left[i] = len; m_chain[i] = chain;
    m_we[i]  = 1'($urandom_range(0, 1));
    m_sel[i] = 4'($urandom_range(0, 15));
    m_bte[i] = 2'($urandom_range(0, 3));
    m_adr[i] = $urandom; m_dat[i] = $urandom;
  endtask

  task automatic start_rand(input int i);
    bit b;
    b = 1'($urandom_range(0, 1));
    new_txn(i, b, b ? ($urandom_range(0, 1) ? 4 : 8) : $urandom_range(1, 3), 0);
  endtask

  task automatic clear_masters();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_burst[i] = 0; m_auto[i] = 0; m_left[i] = 0; m_chain[i] = 0;
      m_we[i] = 0; m_adr[i] = 0; m_dat[i] = 0; m_sel[i] = 0; m_bte[i] = 0;
    end
  endtask

  task automatic clear_track();
    exp_q.delete(); ten_own_q.delete(); ten_ack_q.delete(); ten_dead_q.delete();
    ten_start_q.delete(); ten_lack_q.delete(); ten_cti_q.delete();
    cur_acks = 0; cur_dead = 0; cur_last_ack = 0; cur_cti = 0;
    wdt_ev = 0; wdt_cyc = 0; prev_grant = '0; ob_grant = '0; ob_ack = '0;
    for (int i = 0; i < N; i++) begin ack_cnt[i] = 0; err_cnt[i] = 0; end
  endtask

  task automatic model_reset();
    md_owner = -1; md_last = N - 1; md_beats = 0; md_stall = 0; md_cool = 0;
  endtask

  // reset is asserted just after a rising edge: outputs must clear at once
  task automatic do_reset();
    wb_rst_n = 1'b0;
    #2;
    chk("rst_grant", grant_o, 0);
    chk("rst_bus", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o,
                    wbs_sel_o, wbs_cti_o, wbs_bte_o}, 0);
    chk("rst_resp", {wbm_ack_o, wbm_err_o, wdt_event_o}, 0);
    wbm_cyc_i = '0; wbm_stb_i = '0; wbs_ack_i = 1'b0;
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    clear_masters();
    model_reset();
    @(posedge wb_clk); #1;
  endtask

  // driver + per-cycle check + model step; called just after a rising edge
  task automatic cycle();
    logic [N-1:0] cyc, stb, eg, ea, ee;
    logic [2:0]   cti[N];
    logic         a, fire;
    logic [75:0]  eb;
    logic [31:0]  sdat;
    int           o;
    for (int i = 0; i < N; i++) begin
      cyc[i] = m_act[i];
      stb[i] = m_act[i] && !(gap_en && $urandom_range(0, 7) == 0);
      cti[i] = !m_burst[i] ? 3'b000 : (m_left[i] == 1 ? 3'b111 : 3'b010);
    end
    if (force_drop0) cyc[0] = 1'b0;
    o = md_owner;
    a = 1'b0;
    if (o >= 0 && stb[o] && !hang_mask[o] && hang_left == 0 &&
        $urandom_range(1, 100) <= ack_pct) a = 1'b1;
    sdat = $urandom;
    wbm_cyc_i = cyc; wbm_stb_i = stb;
    for (int i = 0; i < N; i++) begin
      wbm_we_i[i] = m_we[i];
      wbm_adr_i[32*i +: 32] = m_adr[i];
      wbm_dat_i[32*i +: 32] = m_dat[i];
      wbm_sel_i[4*i +: 4]   = m_sel[i];
      wbm_cti_i[3*i +: 3]   = cti[i];
      wbm_bte_i[2*i +: 2]   = m_bte[i];
    end
    wbs_ack_i = a; wbs_dat_i = sdat;
    @(negedge wb_clk);

    eg = '0; ea = '0; ee = '0; eb = '0; fire = 1'b0;
    if (o >= 0) begin
      fire  = stb[o] && !a && (md_stall == TMO - 1);
      eg[o] = 1'b1; ea[o] = a; ee[o] = fire;
      eb = {cyc[o] && !fire, stb[o] && !fire, m_we[o], m_adr[o], m_dat[o],
            m_sel[o], cti[o], m_bte[o]};
    end
    chk("grant", grant_o, eg);
    chk("wbs_bus", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o,
                    wbs_sel_o, wbs_cti_o, wbs_bte_o}, eb);
    chk("ack", wbm_ack_o, ea);
    chk("err", wbm_err_o, ee);
    chk("wdt_event", wdt_event_o, fire);
    chk("dat_o", wbm_dat_o, sdat);
    chk("rty", wbm_rty_o, 0);

    ob_grant = grant_o; ob_ack = wbm_ack_o; ob_state = state_dbg;
    if (ob_grant == 0 && prev_grant != 0) begin
      ten_ack_q.push_back(cur_acks); ten_cti_q.push_back(cur_cti);
      ten_lack_q.push_back(cur_last_ack); cur_dead = 0;
    end
    if (ob_grant == 0) cur_dead++;
    if (ob_grant != 0 && prev_grant == 0) begin
      ten_own_q.push_back(ob_grant); ten_dead_q.push_back(cur_dead);
      ten_start_q.push_back(cyc_n); cur_acks = 0;
    end
    if ((ob_ack & ob_grant) != 0) begin
      cur_acks++; cur_cti = wbs_cti_o; cur_last_ack = cyc_n;
    end
    for (int i = 0; i < N; i++) begin
      if (wbm_ack_o[i]) ack_cnt[i]++;
      if (wbm_err_o[i]) err_cnt[i]++;
    end
    if (wdt_event_o) begin wdt_ev++; wdt_cyc = cyc_n; end
    prev_grant = ob_grant;

    for (int i = 0; i < N; i++) begin
      if (ee[i]) begin
        m_act[i] = 0; m_left[i] = 0;
      end else if (ea[i]) begin
        m_left[i]--; m_adr[i] = $urandom; m_dat[i] = $urandom;
        if (m_left[i] == 0) begin
          if (m_chain[i] > 0) m_left[i] = m_chain[i];
          else if (m_auto[i] && $urandom_range(0, 1) == 1) start_rand(i);
          else m_act[i] = 0;
        end
      end else if (!m_act[i] && m_auto[i] && $urandom_range(0, 5) == 0) begin
        start_rand(i);
      end
    end
    if (force_drop0) m_act[0] = 0;
    if (rnd_hang) begin
      if (hang_left > 0) hang_left--;
      else if ($urandom_range(0, 99) < 2) hang_left = 12;
    end

    if (o >= 0) begin
      md_beats = (md_beats + int'(a) > MAXB) ? MAXB : md_beats + int'(a);
      if (a) md_stall = 0;
      else if (stb[o]) md_stall++;
      if (!cyc[o] || fire ||
          (md_beats == MAXB && a && (cti[o] == 3'b000 || cti[o] == 3'b111) && (cyc & ~eg) != 0)) begin
        md_owner = -1; md_cool = 1;
      end
    end else if (md_cool) begin
      md_cool = 0;
    end else if (cyc != 0) begin
      md_owner = rr_pick(cyc, md_last);
      md_last = md_owner; md_beats = 0; md_stall = 0;
    end
    @(posedge wb_clk); #1;
    cyc_n++;
  endtask

  initial begin
    wb_rst_n = 1'b0;
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_we_i = '0; wbm_adr_i = '0; wbm_dat_i = '0;
    wbm_sel_i = '0; wbm_cti_i = '0; wbm_bte_i = '0; wbs_ack_i = 1'b0; wbs_dat_i = '0;
    gap_en = 0; force_drop0 = 0; rnd_hang = 0; hang_left = 0; hang_mask = '0;
    ack_pct = 100; cyc_n = 0;
    clear_masters(); model_reset(); clear_track();
    @(posedge wb_clk); #1;
    do_reset();

    // fairness: three continuous classic requesters
    clear_track();
    for (int i = 0; i < N; i++) new_txn(i, 0, 1000, 0);
    for (int k = 0; k < 200 && ten_own_q.size() < 7; k++) cycle();
    chk("fair_tenures", ten_own_q.size() >= 7, 1);
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 6; k++) chk("fair_order", ten_own_q[k], exp_q.pop_front());
    for (int k = 0; k < 6; k++) chk("fair_acks", ten_ack_q[k], MAXB);
    for (int k = 1; k < 7; k++) chk("fair_dead", ten_dead_q[k], 2);
    do_reset();

    // single master 32-beat burst: never preempted
    clear_track();
    new_txn(2, 1, 32, 0);
    for (int k = 0; k < 200 && ten_ack_q.size() < 1; k++) cycle();
    for (int k = 0; k < 4; k++) cycle();
    chk("single_owner", ten_own_q[0], 3'b100);
    chk("single_acks", ack_cnt[2], 32);
    chk("single_other_acks", ack_cnt[0] + ack_cnt[1], 0);
    chk("single_tenures", ten_own_q.size(), 1);
    do_reset();

    // preemption at a burst boundary after the beat budget is used
    clear_track();
    new_txn(0, 1, 2, 4);
    new_txn(1, 1, 4, 0);
    for (int k = 0; k < 200 && ten_own_q.size() < 2; k++) cycle();
    chk("pre_first", ten_own_q[0], 3'b001);
    chk("pre_second", ten_own_q[1], 3'b010);
    chk("pre_acks", ten_ack_q[0], 18);
    chk("pre_last_cti", ten_cti_q[0], 3'b111);
    chk("pre_gap", ten_start_q[1] - ten_lack_q[0], 3);
    do_reset();

    // watchdog: slave never answers master 1
    clear_track();
    hang_mask = 3'b010;
    new_txn(1, 0, 1, 0);
    new_txn(2, 0, 1, 0);
    for (int k = 0; k < 100 && ten_own_q.size() < 2; k++) cycle();
    for (int k = 0; k < 4; k++) cycle();
    chk("wdt_owner", ten_own_q[0], 3'b010);
    chk("wdt_err_pulses", err_cnt[1], 1);
    chk("wdt_event_pulses", wdt_ev, 1);
    chk("wdt_time", wdt_cyc - ten_start_q[0], TMO - 1);
    chk("wdt_acks", ten_ack_q[0], 0);
    chk("wdt_next", ten_own_q[1], 3'b100);
    hang_mask = '0;
    do_reset();

    // cyc dropped in the same cycle as the final ack
    clear_track();
    ack_pct = 0;
    new_txn(0, 0, 1, 0);
    for (int k = 0; k < 20 && ob_grant != 3'b001; k++) cycle();
    force_drop0 = 1; ack_pct = 100;
    cycle();
    chk("drop_ack", ob_ack, 3'b001);
    force_drop0 = 0;
    cycle();
    chk("drop_rel_grant", ob_grant, 0);
    chk("drop_rel_state", ob_state, 2'd2);
    cycle();
    chk("drop_idle_state", ob_state, 2'd0);
    do_reset();

    // reset in the middle of master 1's burst, then master 0 alone
    clear_track();
    new_txn(1, 1, 4, 0);
    for (int k = 0; k < 20 && ob_grant != 3'b010; k++) cycle();
    cycle();
    do_reset();
    new_txn(0, 0, 2, 0);
    cycle();
    chk("rst_idle", ob_grant, 0);
    cycle();
    chk("rst_regrant", ob_grant, 3'b001);
    for (int k = 0; k < 4; k++) cycle();
    do_reset();

    // randomized traffic with stb holes, slave stalls and occasional resets
    clear_track();
    gap_en = 1; rnd_hang = 1; ack_pct = 70;
    for (int i = 0; i < N; i++) m_auto[i] = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        for (int i = 0; i < N; i++) m_auto[i] = 1;
      end
      cycle();
    end
    chk("rnd_activity", (ack_cnt[0] + ack_cnt[1] + ack_cnt[2]) > 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
